// File: rtl/fu_output_queue.sv
// Tagged result FIFO between a functional unit and a shared result bus.
// Requests the bus while non-empty and drives it only while the arbiter grants a permit.
module fu_output_queue #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [XLEN-1:0]              value,
  input  logic [TAG_WIDTH-1:0]         tag,
  input  logic                         write_en,
  output logic                         ready,
  input  logic                         flush,
  input  logic                         data_bus_permit,
  output logic                         not_empty,
  output logic [TAG_WIDTH-1:0]         head_tag,
  output logic [XLEN-1:0]              data_bus_data,
  output logic [TAG_WIDTH-1:0]         data_bus_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]      value_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem   [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count_q;
  logic                 overflow_q, underflow_q;

  logic is_empty, is_full, do_enq, do_deq, do_drop, do_empty_permit;

  always_comb begin
    is_empty        = (count_q == '0);
    is_full         = (count_q == CNT_W'(DEPTH));
    // A full queue still accepts a write when the head retires on the same edge.
    do_deq          = data_bus_permit && !is_empty && !flush;
    do_enq          = write_en && !flush && (!is_full || data_bus_permit);
    do_drop         = write_en && !flush && is_full && !data_bus_permit;
    do_empty_permit = data_bus_permit && is_empty && !flush;
  end

  // NOTE: storage is reset too, so a freshly reset queue presents deterministic head contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        value_mem[i] <= '0;
        tag_mem[i]   <= '0;
      end
      valid_q     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_drop)         overflow_q  <= 1'b1;
      if (do_empty_permit) underflow_q <= 1'b1;
      if (flush) begin
        valid_q <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        // Dequeue is written before enqueue so that a full-queue write reusing
        // the retiring slot leaves that slot marked valid.
        if (do_deq) begin
          valid_q[rd_ptr] <= 1'b0;
          rd_ptr          <= rd_ptr + PTR_W'(1);
        end
        if (do_enq) begin
          value_mem[wr_ptr] <= value;
          tag_mem[wr_ptr]   <= tag;
          valid_q[wr_ptr]   <= 1'b1;
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        case ({do_enq, do_deq})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign count         = count_q;
  assign not_empty     = !is_empty;
  assign full          = is_full;
  assign ready         = !is_full;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign head_tag      = valid_q[rd_ptr] ? tag_mem[rd_ptr] : '0;
  assign data_bus_data = data_bus_permit ? value_mem[rd_ptr] : 'z;
  assign data_bus_tag  = data_bus_permit ? tag_mem[rd_ptr]   : 'z;

endmodule

// File: tb/tb_fu_output_queue.sv
// Self-checking bench for fu_output_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fu_output_queue;

  localparam int XLEN      = 32;
  localparam int TAG_WIDTH = 32;
  localparam int DEPTH     = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [XLEN-1:0]            value;
  logic [TAG_WIDTH-1:0]       tag;
  logic                       write_en;
  logic                       ready;
  logic                       flush;
  logic                       data_bus_permit;
  logic                       not_empty;
  logic [TAG_WIDTH-1:0]       head_tag;
  logic [XLEN-1:0]            data_bus_data;
  logic [TAG_WIDTH-1:0]       data_bus_tag;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       overflow;
  logic                       underflow;

  fu_output_queue #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .value(value), .tag(tag), .write_en(write_en),
    .ready(ready), .flush(flush), .data_bus_permit(data_bus_permit),
    .not_empty(not_empty), .head_tag(head_tag), .data_bus_data(data_bus_data),
    .data_bus_tag(data_bus_tag), .count(count), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]      v;
    logic [TAG_WIDTH-1:0] t;
  } entry_t;

  entry_t model_q[$];
  logic   model_ovf;
  logic   model_unf;
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every visible output against the model's pre-edge state.
  task automatic compare_all();
    int n = model_q.size();
    check("count",     64'(count),     64'(n));
    check("not_empty", 64'(not_empty), 64'(n != 0));
    check("full",      64'(full),      64'(n == DEPTH));
    check("ready",     64'(ready),     64'(n != DEPTH));
    check("head_tag",  64'(head_tag),  (n != 0) ? 64'(model_q[0].t) : 64'd0);
    check("overflow",  64'(overflow),  64'(model_ovf));
    check("underflow", 64'(underflow), 64'(model_unf));
    if (data_bus_permit && n != 0) begin
      check("bus_tag",  64'(data_bus_tag),  64'(model_q[0].t));
      check("bus_data", 64'(data_bus_data), 64'(model_q[0].v));
    end
  endtask

  task automatic model_edge();
    logic deq, wr_ok;
    if (flush) begin
      model_q.delete();
    end else begin
      deq   = data_bus_permit && (model_q.size() != 0);
      wr_ok = write_en && ((model_q.size() < DEPTH) || deq);
      if (data_bus_permit && model_q.size() == 0) model_unf = 1'b1;
      if (write_en && !wr_ok) model_ovf = 1'b1;
      if (deq) void'(model_q.pop_front());
      if (wr_ok) model_q.push_back('{v: value, t: tag});
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are checked on the falling edge.
  task automatic cycle(input logic we, input logic [TAG_WIDTH-1:0] t,
                       input logic pm, input logic fl);
    write_en        = we;
    value           = $urandom;
    tag             = t;
    data_bus_permit = pm;
    flush           = fl;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset();
    write_en = 1'b0; data_bus_permit = 1'b0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    compare_all();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; value = '0; tag = '0; write_en = 1'b0;
    flush = 1'b0; data_bus_permit = 1'b0;
    model_ovf = 1'b0; model_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // Fill, drop a fifth write, drain in order.
    for (int i = 1; i <= 4; i++) cycle(1'b1, TAG_WIDTH'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    // Full queue accepts a write alongside a permit.
    for (int i = 1; i <= 4; i++) cycle(1'b1, TAG_WIDTH'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'd9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    // Streaming at occupancy 1 wraps the pointers.
    cycle(1'b1, 32'd100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, TAG_WIDTH'(101 + i), 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    // Flush wins over a simultaneous write and permit.
    for (int i = 0; i < 3; i++) cycle(1'b1, TAG_WIDTH'(20 + i), 1'b0, 1'b0);
    cycle(1'b1, 32'd77, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, TAG_WIDTH'(30 + i), 1'b0, 1'b0);
    async_reset();
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    // Permit while empty sets a sticky underflow that survives flush.
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 32'd44, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    async_reset();
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(199) == 0) async_reset();
      else cycle($urandom_range(99) < 60, $urandom, $urandom_range(99) < 45,
                 $urandom_range(99) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
